// File: rtl/avmm_arb_pkg.sv
// rtl/avmm_arb_pkg.sv - shared types and default widths for the AVMM burst arbiter
package avmm_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_CMD  = 2'd1,
        ST_RD_DATA = 2'd2,
        ST_WR      = 2'd3
    } arb_state_e;

    localparam int DEF_NUM_CH  = 2;
    localparam int DEF_DATA_W  = 128;
    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_BURST_W = 11;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first requester at or after ptr
module rr_arbiter #(
    parameter int NUM_CH = 2,
    localparam int PW    = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [PW-1:0]     ptr,
    output logic              gnt_valid,
    output logic [PW-1:0]     gnt_idx
);

    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % NUM_CH]) begin
                gnt_valid = 1'b1;
                gnt_idx   = PW'((int'(ptr) + i) % NUM_CH);
            end
        end
    end

endmodule

// File: rtl/avmm_burst_arbiter.sv
// rtl/avmm_burst_arbiter.sv - NUM_CH-to-1 Avalon-MM burst arbiter, one burst in flight
module avmm_burst_arbiter
    import avmm_arb_pkg::*;
#(
    parameter int NUM_CH  = DEF_NUM_CH,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int BURST_W = DEF_BURST_W
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CH-1:0]              s_read,
    input  logic [NUM_CH-1:0]              s_write,
    input  logic [NUM_CH*ADDR_W-1:0]       s_address,
    input  logic [NUM_CH*BURST_W-1:0]      s_burstcount,
    input  logic [NUM_CH*DATA_W-1:0]       s_writedata,
    input  logic [NUM_CH*(DATA_W/8)-1:0]   s_byteenable,
    output logic [NUM_CH-1:0]              s_waitrequest,
    output logic [DATA_W-1:0]              s_readdata,
    output logic [NUM_CH-1:0]              s_readdatavalid,
    output logic                           m_read,
    output logic                           m_write,
    output logic [ADDR_W-1:0]              m_address,
    output logic [BURST_W-1:0]             m_burstcount,
    output logic [DATA_W-1:0]              m_writedata,
    output logic [DATA_W/8-1:0]            m_byteenable,
    input  logic                           m_waitrequest,
    input  logic [DATA_W-1:0]              m_readdata,
    input  logic                           m_readdatavalid,
    output logic [$clog2(NUM_CH)-1:0]      grant_ch,
    output logic                           busy
);

    localparam int PW   = $clog2(NUM_CH);
    localparam int BE_W = DATA_W / 8;

    arb_state_e           state_q, state_d;
    logic [PW-1:0]        grant_q, grant_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [BURST_W-1:0]   burst_q, burst_d;
    logic [BURST_W-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]        rr_ptr_q, rr_ptr_d;

    logic                 arb_valid;
    logic [PW-1:0]        arb_idx;
    logic [BURST_W-1:0]   win_burst;
    logic [PW-1:0]        next_ptr;
    logic                 last_beat;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_rr (
        .req       (s_read | s_write),
        .ptr       (rr_ptr_q),
        .gnt_valid (arb_valid),
        .gnt_idx   (arb_idx)
    );

    assign win_burst = s_burstcount[int'(arb_idx)*BURST_W +: BURST_W];
    assign next_ptr  = (grant_q == PW'(NUM_CH - 1)) ? '0 : grant_q + PW'(1);
    assign last_beat = (cnt_q + BURST_W'(1)) == burst_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            addr_q   <= '0;
            burst_q  <= '0;
            cnt_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            addr_q   <= addr_d;
            burst_q  <= burst_d;
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // A zero burstcount is latched as 1 so the beat counter always terminates.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        addr_d   = addr_q;
        burst_d  = burst_q;
        cnt_d    = cnt_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    grant_d = arb_idx;
                    addr_d  = s_address[int'(arb_idx)*ADDR_W +: ADDR_W];
                    burst_d = (win_burst == '0) ? BURST_W'(1) : win_burst;
                    cnt_d   = '0;
                    state_d = s_read[arb_idx] ? ST_RD_CMD : ST_WR;
                end
            end
            ST_RD_CMD: begin
                if (!m_waitrequest) begin
                    cnt_d   = '0;
                    state_d = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (m_readdatavalid) begin
                    cnt_d = cnt_q + BURST_W'(1);
                    if (last_beat) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = next_ptr;
                    end
                end
            end
            ST_WR: begin
                if (s_write[grant_q] && !m_waitrequest) begin
                    cnt_d = cnt_q + BURST_W'(1);
                    if (last_beat) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = next_ptr;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        s_waitrequest   = '1;
        s_readdatavalid = '0;
        m_read          = 1'b0;
        m_write         = 1'b0;
        case (state_q)
            ST_RD_CMD: begin
                m_read                 = 1'b1;
                s_waitrequest[grant_q] = m_waitrequest;
            end
            ST_RD_DATA: s_readdatavalid[grant_q] = m_readdatavalid;
            ST_WR: begin
                m_write                = s_write[grant_q];
                s_waitrequest[grant_q] = m_waitrequest;
            end
            default: ;
        endcase
    end

    assign m_address    = addr_q;
    assign m_burstcount = burst_q;
    assign m_writedata  = s_writedata[int'(grant_q)*DATA_W +: DATA_W];
    assign m_byteenable = s_byteenable[int'(grant_q)*BE_W +: BE_W];
    assign s_readdata   = m_readdata;
    assign grant_ch     = grant_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_avmm_burst_arbiter.sv
// tb/tb_avmm_burst_arbiter.sv - self-checking bench for avmm_burst_arbiter (4 channels)
module tb_avmm_burst_arbiter;

    localparam int N   = 4;
    localparam int TMO = 3000;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   s_read, s_write, s_waitrequest, s_readdatavalid;
    logic [N*32-1:0]  s_address;
    logic [N*11-1:0]  s_burstcount;
    logic [N*128-1:0] s_writedata;
    logic [N*16-1:0]  s_byteenable;
    logic [127:0]   s_readdata;
    logic           m_read, m_write, m_waitrequest, m_readdatavalid;
    logic [31:0]    m_address;
    logic [10:0]    m_burstcount;
    logic [127:0]   m_writedata, m_readdata;
    logic [15:0]    m_byteenable;
    logic [1:0]     grant_ch;
    logic           busy;

    avmm_burst_arbiter #(.NUM_CH(N), .DATA_W(128), .ADDR_W(32), .BURST_W(11)) dut (
        .clk(clk), .rst(rst),
        .s_read(s_read), .s_write(s_write), .s_address(s_address),
        .s_burstcount(s_burstcount), .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
        .m_read(m_read), .m_write(m_write), .m_address(m_address), .m_burstcount(m_burstcount),
        .m_writedata(m_writedata), .m_byteenable(m_byteenable), .m_waitrequest(m_waitrequest),
        .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
        .grant_ch(grant_ch), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    function automatic void chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endfunction

    function automatic logic [127:0] rd_data(input logic [31:0] a, input int b);
        return {a, 32'(b), ~a, 32'hA5A5_0000 ^ 32'(b)};
    endfunction

    function automatic logic [127:0] wr_data(input int c, input logic [31:0] a, input int b);
        return {a, 32'(c), 32'hDEAD_0000 + 32'(b), ~a ^ 32'(b * 7)};
    endfunction

    function automatic logic [15:0] wr_be(input int c, input int b);
        return 16'hF0F0 ^ 16'(b * 37 + c);
    endfunction

    // Per-channel operation lists driven by the channel masters.
    bit          op_rd[N][4];
    bit          op_wr[N][4];
    logic [31:0] op_addr[N][4];
    int          op_bc[N][4];
    int          op_n[N];

    int          log_ch[$], exp_ch[$], log_bc[$], exp_bc[$];
    bit          log_wr[$], exp_wr[$];
    logic [31:0] log_addr[$], exp_addr[$];
    int          rdv_cnt[N], exp_rdv[N], rd_beat[N];
    logic [31:0] last_rd_addr[N];
    int          exp_ptr;

    // Memory-side BFM: 3-cycle read latency, optional random waitrequest.
    bit          rand_wait;
    int          sl_cd, sl_left, sl_beat, sl_rd_acc, sl_wr_beats;
    logic [31:0] sl_addr;

    initial begin
        bit acc_rd, acc_wr;
        logic [31:0] a;
        int b;
        m_waitrequest = 1'b0; m_readdatavalid = 1'b0; m_readdata = '0;
        sl_cd = 0; sl_left = 0; sl_beat = 0; sl_rd_acc = 0; sl_wr_beats = 0; sl_addr = '0;
        forever begin
            @(negedge clk);
            acc_rd = m_read && !m_waitrequest;
            acc_wr = m_write && !m_waitrequest;
            a = m_address;
            b = int'(m_burstcount);
            @(posedge clk);
            #1;
            m_readdatavalid = 1'b0;
            if (acc_rd) begin
                sl_addr = a; sl_left = (b == 0) ? 1 : b; sl_cd = 3; sl_beat = 0; sl_rd_acc++;
            end else if (sl_cd > 0) begin
                sl_cd--;
            end
            if (acc_wr) sl_wr_beats++;
            if (sl_cd == 0 && sl_left > 0) begin
                m_readdatavalid = 1'b1;
                m_readdata = rd_data(sl_addr, sl_beat);
                sl_beat++; sl_left--;
            end
            m_waitrequest = rand_wait ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    // Grant log (one entry per burst start) and read-beat routing/data checks.
    initial begin
        bit prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (busy && !prev_busy) begin
                log_ch.push_back(int'(grant_ch));
                log_wr.push_back(m_write);
                log_addr.push_back(m_address);
                log_bc.push_back(int'(m_burstcount));
            end
            prev_busy = busy;
            for (int c = 0; c < N; c++) begin
                if (s_readdatavalid[c]) begin
                    rdv_cnt[c]++;
                    chk("rdata", s_readdata, rd_data(last_rd_addr[c], rd_beat[c]));
                    rd_beat[c]++;
                end
            end
        end
    end

    task automatic ch_run(input int c, input bit rd, input bit wr, input logic [31:0] a,
                          input int bc, input bit wait_data);
        int eff;
        bit done;
        eff = (bc == 0) ? 1 : bc;
        s_address[c*32 +: 32]      = a;
        s_burstcount[c*11 +: 11]   = 11'(bc);
        s_writedata[c*128 +: 128]  = wr_data(c, a, 0);
        s_byteenable[c*16 +: 16]   = wr_be(c, 0);
        if (rd) begin
            last_rd_addr[c] = a;
            rd_beat[c] = 0;
        end
        s_read[c]  = rd;
        s_write[c] = wr;
        if (rd) begin
            done = 1'b0;
            for (int t = 0; t < TMO && !done; t++) begin
                @(negedge clk);
                if (!s_waitrequest[c]) begin
                    @(posedge clk);
                    #1;
                    s_read[c] = 1'b0;
                    done = 1'b1;
                end
            end
            if (!done) begin
                chk("rd_accept_timeout", 0, 1);
                s_read[c] = 1'b0;
            end
            for (int t = 0; t < TMO && wait_data && rd_beat[c] < eff; t++) begin
                @(posedge clk);
                #1;
            end
            if (wait_data && rd_beat[c] < eff) chk("rd_data_timeout", rd_beat[c], eff);
        end
        if (wr) begin
            for (int b = 0; b < eff; b++) begin
                s_writedata[c*128 +: 128] = wr_data(c, a, b);
                s_byteenable[c*16 +: 16]  = wr_be(c, b);
                done = 1'b0;
                for (int t = 0; t < TMO && !done; t++) begin
                    @(negedge clk);
                    if (!s_waitrequest[c]) begin
                        chk("wr_strobe", m_write, 1);
                        chk("wr_data", m_writedata, wr_data(c, a, b));
                        chk("wr_be", m_byteenable, wr_be(c, b));
                        chk("wr_addr", m_address, a);
                        chk("wr_burst", m_burstcount, eff);
                        @(posedge clk);
                        #1;
                        done = 1'b1;
                    end
                end
                if (!done) begin
                    chk("wr_accept_timeout", 0, 1);
                    break;
                end
            end
        end
        s_write[c] = 1'b0;
    endtask

    task automatic run_list(input int c);
        for (int i = 0; i < op_n[c]; i++)
            ch_run(c, op_rd[c][i], op_wr[c][i], op_addr[c][i], op_bc[c][i], 1'b1);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int t = 0; t < TMO && !ok; t++) begin
            @(negedge clk);
            ok = !busy && sl_left == 0 && sl_cd == 0;
        end
        if (!ok) chk("idle_timeout", 0, 1);
    endtask

    task automatic clear_run();
        log_ch.delete(); log_wr.delete(); log_addr.delete(); log_bc.delete();
        exp_ch.delete(); exp_wr.delete(); exp_addr.delete(); exp_bc.delete();
        for (int c = 0; c < N; c++) begin
            rdv_cnt[c] = 0; exp_rdv[c] = 0; op_n[c] = 0;
        end
        sl_rd_acc = 0; sl_wr_beats = 0;
    endtask

    task automatic run_ops();
        fork
            run_list(0);
            run_list(1);
            run_list(2);
            run_list(3);
        join
        wait_idle();
    endtask

    function automatic void push_exp(input int c, input bit w, input logic [31:0] a, input int bc);
        exp_ch.push_back(c); exp_wr.push_back(w); exp_addr.push_back(a); exp_bc.push_back(bc);
        if (!w) exp_rdv[c] += bc;
    endfunction

    // Reference: walk channels round-robin from the pointer; each grant consumes one item
    // of that channel's list, a read+write op yielding its read first and its write later.
    function automatic void compute_expected();
        int  idx[N];
        bit  sub[N];
        bit  found;
        int  c, eff;
        for (int k = 0; k < N; k++) begin idx[k] = 0; sub[k] = 1'b0; end
        do begin
            found = 1'b0;
            for (int k = 0; k < N && !found; k++) begin
                c = (exp_ptr + k) % N;
                if (idx[c] < op_n[c]) begin
                    found = 1'b1;
                    eff = (op_bc[c][idx[c]] == 0) ? 1 : op_bc[c][idx[c]];
                    if (op_rd[c][idx[c]] && !sub[c]) begin
                        push_exp(c, 1'b0, op_addr[c][idx[c]], eff);
                        if (op_wr[c][idx[c]]) sub[c] = 1'b1; else idx[c]++;
                    end else begin
                        push_exp(c, 1'b1, op_addr[c][idx[c]], eff);
                        sub[c] = 1'b0;
                        idx[c]++;
                    end
                    exp_ptr = (c + 1) % N;
                end
            end
        end while (found);
    endfunction

    task automatic check_run(input string tag);
        chk({tag, "_ngrants"}, log_ch.size(), exp_ch.size());
        for (int i = 0; i < exp_ch.size() && i < log_ch.size(); i++) begin
            chk({tag, "_grant_ch"}, log_ch[i], exp_ch[i]);
            chk({tag, "_grant_wr"}, log_wr[i], exp_wr[i]);
            chk({tag, "_grant_addr"}, log_addr[i], exp_addr[i]);
            chk({tag, "_grant_burst"}, log_bc[i], exp_bc[i]);
        end
        for (int c = 0; c < N; c++) chk({tag, "_rdv_count"}, rdv_cnt[c], exp_rdv[c]);
    endtask

    typedef struct {
        logic [3:0] rd;
        logic [3:0] wr;
        int         n;
        int         code[4];  // ch*10 + is_write, in expected grant order
    } vec_t;

    vec_t tbl[5];

    task automatic set_vec(input int i, input logic [3:0] rd, input logic [3:0] wr, input int n,
                           input int c0, input int c1, input int c2, input int c3);
        tbl[i].rd = rd; tbl[i].wr = wr; tbl[i].n = n;
        tbl[i].code[0] = c0; tbl[i].code[1] = c1; tbl[i].code[2] = c2; tbl[i].code[3] = c3;
    endtask

    initial begin
        int spurious, late, ch;
        rst = 1'b1;
        s_read = '0; s_write = '0; s_address = '0; s_burstcount = '0;
        s_writedata = '0; s_byteenable = '0;
        rand_wait = 1'b0;
        exp_ptr = 0;
        for (int c = 0; c < N; c++) begin rdv_cnt[c] = 0; rd_beat[c] = 0; last_rd_addr[c] = '0; end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_m_read", m_read, 0);
        chk("rst_m_write", m_write, 0);
        chk("rst_waitreq", s_waitrequest, 4'hF);
        chk("rst_rdv", s_readdatavalid, 0);
        chk("rst_grant", grant_ch, 0);
        rst = 1'b0;

        set_vec(0, 4'b1111, 4'b0000, 4, 0, 10, 20, 30);
        set_vec(1, 4'b0101, 4'b0000, 2, 0, 20, 0, 0);
        set_vec(2, 4'b1000, 4'b0010, 2, 30, 11, 0, 0);
        set_vec(3, 4'b0001, 4'b0011, 3, 0, 11, 1, 0);
        set_vec(4, 4'b0100, 4'b0001, 2, 20, 1, 0, 0);
        for (int v = 0; v < 5; v++) begin
            clear_run();
            for (int c = 0; c < N; c++) begin
                op_n[c]       = (tbl[v].rd[c] | tbl[v].wr[c]) ? 1 : 0;
                op_rd[c][0]   = tbl[v].rd[c];
                op_wr[c][0]   = tbl[v].wr[c];
                op_addr[c][0] = 32'h1000_0000 + 32'(v * 256 + c * 16);
                op_bc[c][0]   = 2;
            end
            for (int i = 0; i < tbl[v].n; i++) begin
                ch = tbl[v].code[i] / 10;
                push_exp(ch, bit'(tbl[v].code[i] % 10), op_addr[ch][0], 2);
            end
            exp_ptr = (tbl[v].code[tbl[v].n - 1] / 10 + 1) % N;
            run_ops();
            check_run("vec");
        end

        clear_run();
        op_n[0] = 1; op_rd[0][0] = 1'b1; op_wr[0][0] = 1'b0;
        op_addr[0][0] = 32'h2000_0000; op_bc[0][0] = 4;
        compute_expected();
        run_ops();
        check_run("single_rd");
        chk("single_rd_cmds", sl_rd_acc, 1);

        clear_run();
        rand_wait = 1'b1;
        op_n[1] = 1; op_rd[1][0] = 1'b0; op_wr[1][0] = 1'b1;
        op_addr[1][0] = 32'h3000_0040; op_bc[1][0] = 8;
        compute_expected();
        run_ops();
        check_run("wr8");
        chk("wr8_beats", sl_wr_beats, 8);
        rand_wait = 1'b0;

        clear_run();
        ch_run(0, 1'b1, 1'b0, 32'h4000_0000, 16, 1'b0);
        for (int t = 0; t < 200 && rdv_cnt[0] < 2; t++) begin
            @(negedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_m_read", m_read, 0);
        chk("midrst_waitreq", s_waitrequest, 4'hF);
        chk("midrst_grant", grant_ch, 0);
        chk("midrst_rdv", s_readdatavalid, 0);
        rst = 1'b0;
        spurious = 0; late = 0;
        repeat (20) begin
            @(negedge clk);
            if (m_readdatavalid) begin
                late++;
                if (s_readdatavalid != '0) spurious++;
            end
        end
        chk("late_rdv_spurious", spurious, 0);
        chk("late_rdv_present", late > 0, 1);
        chk("midrst_beats", rdv_cnt[0], 2);
        exp_ptr = 0;
        wait_idle();

        // Zero-length reads on ch1 and ch3: order also shows the pointer came back to 0.
        clear_run();
        op_n[1] = 1; op_rd[1][0] = 1'b1; op_wr[1][0] = 1'b0; op_addr[1][0] = 32'h5000_0100; op_bc[1][0] = 0;
        op_n[3] = 1; op_rd[3][0] = 1'b1; op_wr[3][0] = 1'b0; op_addr[3][0] = 32'h5000_0300; op_bc[3][0] = 0;
        compute_expected();
        run_ops();
        check_run("bc0");
        chk("bc0_first_ch", log_ch.size() > 0 ? log_ch[0] : -1, 1);
        chk("bc0_busy_after", busy, 0);

        for (int r = 0; r < 4; r++) begin
            clear_run();
            rand_wait = 1'b1;
            for (int c = 0; c < N; c++) begin
                op_n[c] = $urandom_range(0, 3);
                for (int i = 0; i < 4; i++) begin
                    int kind;
                    kind = $urandom_range(0, 2);
                    op_rd[c][i]   = (kind != 1);
                    op_wr[c][i]   = (kind != 0);
                    op_addr[c][i] = $urandom() & 32'hFFFF_FFF0;
                    op_bc[c][i]   = $urandom_range(0, 6);
                end
            end
            compute_expected();
            run_ops();
            check_run("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
